// File: rtl/pov_spi_tx_pkg.sv
// Shared fixed-point format and vector ordering for the POV vector link (transmitter and receiver).
// Also holds the transmitter FSM state encoding.
package pov_spi_tx_pkg;

    localparam int F_W    = 24;
    localparam int Q_INT  = 8;
    localparam int Q_FRAC = F_W - Q_INT;
    localparam int N_VEC  = 6;

    // Frame order; PLAYER_X occupies the most significant slot and is sent first.
    typedef enum logic [2:0] {
        PLAYER_X = 3'd0,
        PLAYER_Y = 3'd1,
        FACING_X = 3'd2,
        FACING_Y = 3'd3,
        VPLANE_X = 3'd4,
        VPLANE_Y = 3'd5
    } vec_idx_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_TRAIL,
        ST_GAP
    } tx_state_e;

endpackage

// File: rtl/pov_spi_tx_spi_clk_div.sv
// Half-period divider: loads DIV-1 on load, counts down to zero, and holds there.
// tc is high while the count is zero, so a phase lasts exactly DIV cycles after its load.
module spi_clk_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tc
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tc = (cnt == 8'd0);

endmodule

// File: rtl/pov_spi_tx.sv
// SPI mode-0 transmitter: snapshots six W-bit view vectors on start and sends them MSB first in one ss_n frame.
// Optional macro POV_TX_REPEAT_EN lets i_frame_tick start a frame like i_start; all outputs are registered.
module pov_spi_tx
    import pov_spi_tx_pkg::*;
#(
    parameter int W       = F_W,
    parameter int CLK_DIV = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [W-1:0] i_playerX,
    input  logic [W-1:0] i_playerY,
    input  logic [W-1:0] i_facingX,
    input  logic [W-1:0] i_facingY,
    input  logic [W-1:0] i_vplaneX,
    input  logic [W-1:0] i_vplaneY,
    input  logic         i_frame_tick,
    output logic         o_sclk,
    output logic         o_mosi,
    output logic         o_ss_n,
    output logic         o_busy,
    output logic         o_done
);

    localparam int BITS = N_VEC * W;
    localparam int BC_W = $clog2(BITS + 1);

    tx_state_e       state, state_nx;
    logic [BITS-1:0] sr;
    logic [BC_W-1:0] bit_cnt;
    logic            tc, trig;
    logic            div_load, load, shift;
    logic            sclk_nx, ss_n_nx, busy_nx, done_nx;

`ifdef POV_TX_REPEAT_EN
    assign trig = i_start | i_frame_tick;
`else
    logic unused_tick;
    assign unused_tick = i_frame_tick;
    assign trig        = i_start;
`endif

    spi_clk_div #(.DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .load  (div_load),
        .tc    (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_load = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_nx = ST_LOW;
                    load     = 1'b1;
                    div_load = 1'b1;
                end
            end
            ST_LOW: begin
                if (tc) begin
                    state_nx = ST_HIGH;
                    div_load = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tc) begin
                    shift    = 1'b1;
                    div_load = 1'b1;
                    state_nx = (bit_cnt == BC_W'(1)) ? ST_TRAIL : ST_LOW;
                end
            end
            ST_TRAIL: begin
                if (tc) begin
                    state_nx = ST_GAP;
                    div_load = 1'b1;
                end
            end
            ST_GAP: begin
                if (tc) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // Outputs are decoded from the next state so the registered copies line up with it.
        sclk_nx = (state_nx == ST_HIGH);
        ss_n_nx = (state_nx == ST_IDLE) || (state_nx == ST_GAP);
        busy_nx = (state_nx != ST_IDLE);
    end

    // Zero-fill on shift, so mosi returns to 0 once the last bit has left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            o_sclk  <= 1'b0;
            o_ss_n  <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_sclk <= sclk_nx;
            o_ss_n <= ss_n_nx;
            o_busy <= busy_nx;
            o_done <= done_nx;
            if (load) begin
                sr      <= {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY};
                bit_cnt <= BC_W'(BITS);
            end else if (shift) begin
                sr      <= {sr[BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt - BC_W'(1);
            end
        end
    end

    assign o_mosi = sr[BITS-1];

endmodule

// File: tb/tb_pov_spi_tx.sv
// Scoreboard bench for pov_spi_tx: stimulus predicts accepted frames and their timing, a negedge monitor checks the wire.
module tb_pov_spi_tx;

    localparam int W         = 24;
    localparam int CLK_DIV   = 2;
    localparam int BITS      = 6 * W;
    localparam int FIRST_LAT = CLK_DIV;
    localparam int SS_LAT    = (2 * BITS + 1) * CLK_DIV;
    localparam int DONE_LAT  = (2 * BITS + 2) * CLK_DIV;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_start = 1'b0;
    logic         i_frame_tick = 1'b0;
    logic [W-1:0] i_playerX = '0, i_playerY = '0, i_facingX = '0;
    logic [W-1:0] i_facingY = '0, i_vplaneX = '0, i_vplaneY = '0;
    logic         o_sclk, o_mosi, o_ss_n, o_busy, o_done;

    pov_spi_tx #(.W(W), .CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_playerX    (i_playerX),
        .i_playerY    (i_playerY),
        .i_facingX    (i_facingX),
        .i_facingY    (i_facingY),
        .i_vplaneX    (i_vplaneX),
        .i_vplaneY    (i_vplaneY),
        .i_frame_tick (i_frame_tick),
        .o_sclk       (o_sclk),
        .o_mosi       (o_mosi),
        .o_ss_n       (o_ss_n),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [BITS-1:0] exp_q[$];
    int              e0_q[$];
    int              done_q[$];
    int              next_ok = 0;

    task automatic chk(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [BITS-1:0] rnd_frame();
        logic [BITS-1:0] fr = '0;
        for (int k = 0; k < 6; k++) fr = {fr[BITS-W-1:0], W'($urandom)};
        return fr;
    endfunction

    // Reference model: a trigger seen at an edge is taken iff the link has been free since the cycle after the last done.
    task automatic step(input logic st, input logic tk, input logic [BITS-1:0] fr);
        int   edge_n;
        logic trig;
        @(posedge clk);
        #1;
        i_start      = st;
        i_frame_tick = tk;
        {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY} = fr;
        edge_n = cyc + 1;
`ifdef POV_TX_REPEAT_EN
        trig = st | tk;
`else
        trig = st;
`endif
        if (trig && !reset && edge_n >= next_ok) begin
            exp_q.push_back(fr);
            e0_q.push_back(edge_n);
            done_q.push_back(edge_n);
            next_ok = edge_n + DONE_LAT + 1;
        end
    endtask

    // Monitor
    logic [BITS-1:0] rx = '0;
    int              nb = 0;
    int              first_rise = 0;
    logic            prev_sclk = 1'b0;
    logic            prev_ss = 1'b1;

    always @(negedge clk) begin
        int              e0;
        logic [BITS-1:0] fr;
        if (reset) begin
            rx        = '0;
            nb        = 0;
            prev_sclk = 1'b0;
            prev_ss   = 1'b1;
        end else begin
            if (o_sclk && !prev_sclk && !o_ss_n) begin
                if (nb == 0) first_rise = cyc;
                rx = {rx[BITS-2:0], o_mosi};
                nb++;
            end
            if (o_ss_n && !prev_ss) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got frame of %0d bits expected none", nb);
                end else begin
                    fr = exp_q.pop_front();
                    e0 = e0_q.pop_front();
                    chk("frame_bits", BITS'(nb), BITS'(BITS));
                    chk("frame_data", rx, fr);
                    chk("first_rise_lat", BITS'(first_rise - e0), BITS'(FIRST_LAT));
                    chk("ss_rise_lat", BITS'(cyc - e0), BITS'(SS_LAT));
                end
                rx = '0;
                nb = 0;
            end
            if (o_done) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e0 = done_q.pop_front();
                    chk("done_lat", BITS'(cyc - e0), BITS'(DONE_LAT));
                end
            end
            prev_sclk = o_sclk;
            prev_ss   = o_ss_n;
        end
    end

    initial begin
        logic [BITS-1:0] fr;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        next_ok = cyc + 1;

        // Idle after reset: ss_n=1, sclk=0, mosi=0, busy=0, done=0
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", BITS'({o_ss_n, o_sclk, o_mosi, o_busy, o_done}), BITS'(5'b10000));
        end

        // Directed: playerX = ABCDEF, rest zero
        fr = '0;
        fr[BITS-1 -: W] = 24'hABCDEF;
        step(1'b1, 1'b0, fr);
        for (int i = 0; i < DONE_LAT + 20; i++) step(1'b0, 1'b0, rnd_frame());

        // Start held high with inputs changing every cycle
        for (int i = 0; i < 2 * DONE_LAT + 10; i++) step(1'b1, 1'b0, rnd_frame());
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, rnd_frame());

        // Coincident start and tick
        step(1'b1, 1'b1, rnd_frame());
        for (int i = 0; i < DONE_LAT + 5; i++) step(1'b0, 1'b0, rnd_frame());

        // Random starts plus periodic ticks (300-cycle period, shorter than a frame)
        for (int i = 0; i < 6000; i++)
            step(($urandom_range(0, 60) == 0), ((i % 300) == 0), rnd_frame());
        for (int i = 0; i < DONE_LAT + 5; i++) step(1'b0, 1'b0, rnd_frame());

        // Reset during bit 70
        step(1'b1, 1'b0, rnd_frame());
        for (int i = 0; i < (2 * 70 + 1) * CLK_DIV; i++) step(1'b0, 1'b0, rnd_frame());
        #1 reset = 1'b1;
        exp_q.delete();
        e0_q.delete();
        done_q.delete();
        #1 chk("async_reset_idle", BITS'({o_ss_n, o_sclk, o_mosi, o_busy, o_done}), BITS'(5'b10000));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        next_ok = cyc + 1;
        step(1'b1, 1'b0, rnd_frame());
        for (int i = 0; i < DONE_LAT + 5; i++) step(1'b0, 1'b0, rnd_frame());

        // Drain with a bounded wait
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || done_q.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        chk("pending_frames", BITS'(exp_q.size()), BITS'(0));
        chk("pending_dones", BITS'(done_q.size()), BITS'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
